// File: rtl/traffic_light_fsm_if.sv
// traffic_light_fsm_if: groups the intersection controller's I/O.
//   clk_1s   : 1 Hz square wave, asynchronous to clk
//   ped_req  : debounced pedestrian button level, synchronous to clk
//   ns_light : north-south {R,Y,G}, one-hot
//   ew_light : east-west {R,Y,G}, one-hot
//   phase    : current state encoding
//   remain   : seconds left in current phase
//   tick_1s  : one-cycle pulse per observed clk_1s rising edge
//   ped_ack  : one-cycle pulse when a pending pedestrian request is serviced
// Modports: slave = controller, master = whoever drives clk_1s/ped_req.
interface traffic_light_if;
  logic       clk_1s;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic [7:0] remain;
  logic       tick_1s;
  logic       ped_ack;

  modport slave (
    input  clk_1s, ped_req,
    output ns_light, ew_light, phase, remain, tick_1s, ped_ack
  );

  modport master (
    output clk_1s, ped_req,
    input  ns_light, ew_light, phase, remain, tick_1s, ped_ack
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: two-way intersection controller.
// Synchronises the 1 Hz clk_1s into clk, turns each rising edge into a
// one-cycle tick, and steps a six-phase light sequence with a per-phase
// seconds countdown.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : traffic_light_if.slave (clk_1s, ped_req in; lights, phase,
//           remain, tick_1s, ped_ack out)
// Optional feature: define TRAFFIC_PED_EN to enable the pedestrian request
// logic (a pending request shortens the current green to PED_MIN seconds).
// Without it ped_req is ignored and ped_ack is held 0.
module traffic_light_fsm #(
  parameter int GREEN_S  = 20,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 2,
  parameter int PED_MIN  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  traffic_light_if.slave  bus
);

  localparam logic [2:0] NS_G  = 3'd0;
  localparam logic [2:0] NS_Y  = 3'd1;
  localparam logic [2:0] RED_A = 3'd2;
  localparam logic [2:0] EW_G  = 3'd3;
  localparam logic [2:0] EW_Y  = 3'd4;
  localparam logic [2:0] RED_B = 3'd5;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  localparam logic [7:0] GREEN_L  = 8'(GREEN_S);
  localparam logic [7:0] YELLOW_L = 8'(YELLOW_S);
  localparam logic [7:0] ALLRED_L = 8'(ALLRED_S);

  function automatic logic [7:0] dur(input logic [2:0] s);
    case (s)
      NS_Y, EW_Y:   dur = YELLOW_L;
      RED_A, RED_B: dur = ALLRED_L;
      default:      dur = GREEN_L;
    endcase
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] s);
    case (s)
      NS_G:    succ = NS_Y;
      NS_Y:    succ = RED_A;
      RED_A:   succ = EW_G;
      EW_G:    succ = EW_Y;
      EW_Y:    succ = RED_B;
      default: succ = NS_G;
    endcase
  endfunction

  // ---------------------------------------------------------------- tick path
  logic       s1_q, s2_q, prev_q, armed_q;
  // vld_pipe_q marks when s1/s2 hold real samples rather than reset values;
  // without it a clk_1s held high through reset release would arm on the
  // reset-zero in s2 and fire a spurious tick.
  logic [1:0] vld_pipe_q;
  logic       tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      prev_q     <= 1'b0;
      armed_q    <= 1'b0;
      vld_pipe_q <= 2'b00;
    end else begin
      s1_q       <= bus.clk_1s;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      vld_pipe_q <= {vld_pipe_q[0], 1'b1};
      if (vld_pipe_q[1] && !s2_q) armed_q <= 1'b1;
    end
  end

  assign tick = s2_q & ~prev_q & armed_q;

  // ---------------------------------------------------------------- FSM
  logic [2:0] state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic       ack_q, ack_d;
  logic       is_green;

  assign is_green = (state_q == NS_G) || (state_q == EW_G);

`ifdef TRAFFIC_PED_EN
  localparam logic [7:0] PED_THR = 8'(PED_MIN + 1);
  localparam logic [7:0] PED_L   = 8'(PED_MIN);
  logic pend_q, pend_clr, shorten;

  assign shorten = tick && is_green && pend_q && (remain_q > PED_THR);

  // A request arriving on the same clock as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pend_q <= 1'b0;
    else if (bus.ped_req)  pend_q <= 1'b1;
    else if (pend_clr)     pend_q <= 1'b0;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = bus.ped_req;
`endif

  // State register (lights and ack are registered alongside so they change
  // on the same edge as phase/remain).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NS_G;
      remain_q <= GREEN_L;
      ns_q     <= L_GRN;
      ew_q     <= L_RED;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      ns_q     <= ns_d;
      ew_q     <= ew_d;
      ack_q    <= ack_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    ack_d    = 1'b0;
`ifdef TRAFFIC_PED_EN
    pend_clr = 1'b0;
`endif
    if (state_q > RED_B) begin
      // Unreachable encodings recover without waiting for a tick.
      state_d  = NS_G;
      remain_d = GREEN_L;
`ifdef TRAFFIC_PED_EN
    end else if (shorten) begin
      remain_d = PED_L;
      pend_clr = 1'b1;
      ack_d    = 1'b1;
`endif
    end else if (tick) begin
      if (remain_q == 8'd1) begin
        state_d  = succ(state_q);
        remain_d = dur(succ(state_q));
`ifdef TRAFFIC_PED_EN
        // A request too late to shorten is serviced as the green ends.
        if (is_green && pend_q) begin
          pend_clr = 1'b1;
          ack_d    = 1'b1;
        end
`endif
      end else begin
        remain_d = remain_q - 8'd1;
      end
    end
  end

  // Output logic: lights decoded from the next state, then registered.
  always_comb begin
    ns_d = L_RED;
    ew_d = L_RED;
    case (state_d)
      NS_G:    ns_d = L_GRN;
      NS_Y:    ns_d = L_YEL;
      EW_G:    ew_d = L_GRN;
      EW_Y:    ew_d = L_YEL;
      default: ;
    endcase
  end

  assign bus.ns_light = ns_q;
  assign bus.ew_light = ew_q;
  assign bus.phase    = state_q;
  assign bus.remain   = remain_q;
  assign bus.tick_1s  = tick;
  assign bus.ped_ack  = ack_q;

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Two-way intersection controller driven by the 1 Hz square wave from the second-divider stage. Synchronises `clk_1s` into the `clk` domain, converts each rising edge into a one-cycle tick, and runs a six-phase light sequence with a per-phase seconds countdown. An optional pedestrian request shortens the current green. Outputs drive the board LEDs and the countdown display stage.

## Interface
- `GREEN_S`, 20: green duration, seconds (1..255)
- `YELLOW_S`, 3: yellow duration, seconds (1..255)
- `ALLRED_S`, 2: all-red clearance, seconds (1..255)
- `PED_MIN`, 5: remaining green after a pedestrian request is honoured (1..GREEN_S-1)
- `clk`  in  1  system clock, 50 MHz
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `clk_1s`  in  1  1 Hz square wave, asynchronous to `clk` logic; rising edge = one second
- `ped_req`  in  1  debounced pedestrian button, level, synchronous to `clk`
- `ns_light`  out  3  north-south {R,Y,G}, one-hot
- `ew_light`  out  3  east-west {R,Y,G}, one-hot
- `phase`  out  3  current state encoding
- `remain`  out  8  seconds left in current phase, binary
- `tick_1s`  out  1  one-cycle pulse per observed `clk_1s` rising edge
- `ped_ack`  out  1  one-cycle pulse when a pending request is serviced

## Operation
- Tick path: 2-FF synchroniser (`s1`, `s2`), then `prev` register; `tick_1s = s2 & ~prev & armed`. `armed` sets the first cycle `s2` is seen 0 after reset, so a high `clk_1s` at reset release does not produce a tick.
- States and encodings: NS_G=0, NS_Y=1, RED_A=2, EW_G=3, EW_Y=4, RED_B=5; order NS_G→NS_Y→RED_A→EW_G→EW_Y→RED_B→NS_G. Encodings 6–7 are unreachable; if entered, the next clock goes to NS_G with `remain=GREEN_S`.
- Lights: NS_G ns=001/ew=100; NS_Y ns=010/ew=100; RED_A, RED_B both 100; EW_G ns=100/ew=001; EW_Y ns=100/ew=010. Lights are registered from state.
- On a tick: if `remain==1`, advance state and load the new phase's duration. Otherwise decrement `remain`. `remain` is never 0 after reset.
- Pedestrian (feature-gated): `ped_pend` sets on any clock with `ped_req=1`.
  - On a tick in NS_G/EW_G with `ped_pend` and `remain>PED_MIN+1`: load `remain=PED_MIN` instead of decrementing, clear `ped_pend`, pulse `ped_ack`.
  - Otherwise the green runs out normally, and at the tick that leaves green `ped_pend` clears and `ped_ack` pulses.
  - In a same-cycle clear and `ped_req=1`, set wins: `ped_pend` stays 1 and `ped_ack` still pulses.
- Ticks outside green leave `ped_pend` unchanged.

## Timing
- Reset values: `s1`=`s2`=`prev`=`armed`=0, state NS_G, `remain=GREEN_S`, `ns_light=001`, `ew_light=100`, `phase=0`, `tick_1s=0`, `ped_ack=0`, `ped_pend=0`.
- Latency: call the first `clk` edge sampling `clk_1s`=1 edge E1. `tick_1s` is high after E2, and `remain`, state, lights and `ped_ack` update at E3.
- `ped_ack` is coincident with the update at E3 and lasts exactly one cycle.
- Reset asserted mid-phase returns everything to reset values immediately. The first tick after release requires a fresh low-then-high on `clk_1s`.
- Full cycle length: 2·(GREEN_S+YELLOW_S+ALLRED_S) ticks; 50 s with defaults.

## Configuration
- `TRAFFIC_PED_EN` defined: pedestrian logic as above.
- Not defined: `ped_pend` logic removed, `ped_req` ignored, `ped_ack` tied 0, greens always run their full `GREEN_S`.

## Test plan
Bench parameters: `GREEN_S=5`, `YELLOW_S=2`, `ALLRED_S=1`, `PED_MIN=2`; `clk_1s` toggles every 8 `clk` cycles.
- Reset release with `clk_1s=1` -> no `tick_1s` until `clk_1s` goes low then high; `ns_light=001`, `ew_light=100`, `remain=5`.
- 16 ticks -> phase sequence 0,1,2,3,4,5,0 with `remain` loads 5,2,1,5,2,1,5. Lights are one-hot and never both non-red.
- `ped_req` pulse while NS_G `remain=5` -> next tick gives `remain=2`, `ped_ack` one cycle, then NS_Y after 2 more ticks.
- `ped_req` while EW_G `remain=3` -> no shortening (3 is not >3). `remain` counts 2,1, then `ped_ack` at the EW_Y transition.
- `rst_n` low during EW_Y -> immediate phase 0, `remain=5`, `ped_ack=0`.
- Build without `TRAFFIC_PED_EN`, `ped_req` held 1 -> greens last 5 ticks, `ped_ack` constantly 0.
